pcre_payload_feeder: RTL and testbench
======================================

Name: pcre_payload_feeder

Overview:
- Transmit side of the byte-stream interface consumed by the PCRE match engine.
- Pops packet words from a first-word-fall-through payload FIFO and serializes them MSB-byte-first onto an 8-bit stream, framed with start_of_packet/end_of_packet pulses and payload_valid.
- Holds off the next packet until the engine reasserts ready after end_of_packet, so each packet's rule IDs drain before the next start.

Parameters:
- DATA_W, 64: FIFO word width in bits; multiple of 8.
- CNT_W, 4: width of in_bytes; must hold DATA_W/8.
- MAX_BYTES, 1500: bytes forwarded per packet; excess bytes are dropped.
- TIMEOUT_CYC, 4096: ready-wait limit, used only with PCRE_FEED_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_data  in  DATA_W  FIFO head word.
- in_bytes  in  CNT_W  valid bytes in head word; meaningful only when in_eof=1, otherwise DATA_W/8.
- in_sof  in  1  head word is first of packet.
- in_eof  in  1  head word is last of packet.
- in_flow  in  7  flow ID; sampled on the sof word only.
- in_empty  in  1  FIFO empty.
- in_rd_en  out  1  pop head word; FWFT, combinational from state.
- fifo_out  out  8  payload byte.
- flow_out  out  7  flow ID, held for the whole packet.
- start_of_packet  out  1  one-cycle frame start.
- end_of_packet  out  1  one-cycle frame end.
- payload_valid  out  1  fifo_out is valid.
- engine_ready  in  1  engine ready input.
- drop_err  out  1  one-cycle pulse when an orphan word is discarded.
- timeout_err  out  1  one-cycle pulse on ready timeout; constant 0 without the macro.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; flow_out=0.
  - FSM=IDLE; byte index and byte counter cleared.
  - Mid-packet reset abandons the packet with no end_of_packet.
- FSM states: IDLE, SOP, STREAM, EOP, GUARD, WAIT_RDY.
- IDLE:
  - Condition: !in_empty && engine_ready.
  - If in_sof=1: pop the word, latch word/flow/in_bytes/in_eof, go to SOP.
  - If in_sof=0: pop the word, pulse drop_err next cycle, stay in IDLE.
- SOP:
  - start_of_packet=1 for one cycle; payload_valid=0.
  - Go to STREAM; if the latched word has eof with in_bytes=0, go to EOP instead.
- STREAM:
  - Each cycle emit byte[idx] of the latched word; byte 0 = bits [DATA_W-1:DATA_W-8]; payload_valid=1.
  - Last valid byte: DATA_W/8-1, or in_bytes-1 on the eof word.
  - On the last byte of a non-eof word:
    - If !in_empty, pop the next word the same cycle, giving back-to-back bytes with no bubble.
    - Otherwise stall with payload_valid=0 until a word arrives.
  - A non-eof word arriving with in_sof=1 is treated as data.
  - After the last byte of the eof word, go to EOP.
- Byte counter:
  - Counts emitted bytes; saturates at MAX_BYTES.
  - Bytes past MAX_BYTES are not emitted (payload_valid=0), but words are still popped through eof.
- EOP: end_of_packet=1 for one cycle with payload_valid=0; then GUARD.
- GUARD:
  - One cycle; engine_ready is ignored here because the engine drops ready the cycle after end_of_packet.
  - Go to WAIT_RDY.
- WAIT_RDY: wait for engine_ready=1, then go to IDLE.
- Latency:
  - Sof word popped at cycle T → start_of_packet at T+1 → first byte at T+2.
  - An N-byte packet with no FIFO stalls occupies N+2 framing cycles.
- Stream invariant: start_of_packet, payload_valid and end_of_packet are mutually exclusive in every cycle.

Optional Feature:
- Macro: PCRE_FEED_TIMEOUT_EN.
- Defined:
  - WAIT_RDY counts cycles.
  - At TIMEOUT_CYC without engine_ready, pulse timeout_err and go to IDLE.
  - The next packet is still gated by engine_ready in IDLE.
- Undefined:
  - No counter; WAIT_RDY waits indefinitely.
  - timeout_err tied to 0.

Test Plan:
- Single 3-byte packet: word 0xAABBCC.., sof=eof=1, in_bytes=3, flow=5.
  - Expected: pop at T; sop at T+1; bytes AA,BB,CC at T+2..T+4; eop at T+5.
  - flow_out=5 throughout.
- 12-byte packet over two words with FIFO never empty:
  - Expected: 12 consecutive payload_valid cycles, no bubble, eop once.
  - Second word: exactly one in_rd_en, same cycle as byte 7.
- Zero-length packet (sof=eof=1, in_bytes=0):
  - Expected: sop, then eop the next cycle, no payload_valid.
- Ready gating with back-to-back packets queued:
  - Engine holds ready=0 for 20 cycles after eop.
  - Expected: second sop appears only after ready returns; no IDLE pop while ready=0.
- Orphan word (sof=0) at IDLE:
  - Expected: word popped, drop_err pulses once, no framing emitted.
- Reset asserted during STREAM:
  - Expected: outputs 0 immediately (async), no eop.
  - Next sof packet streams normally.
  - With PCRE_FEED_TIMEOUT_EN and TIMEOUT_CYC=16, ready stuck low: timeout_err pulses 16 cycles after entering WAIT_RDY.

Source files
------------

// File: rtl/pcre_payload_feeder.sv
// Serializes FWFT payload FIFO words MSB-byte-first onto the PCRE engine byte stream with SOP/EOP framing.
// Optional ready-wait timeout is compiled in with `define PCRE_FEED_TIMEOUT_EN.
module pcre_payload_feeder #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MAX_BYTES   = 1500,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_bytes,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [6:0]        in_flow,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [7:0]        fifo_out,
  output logic [6:0]        flow_out,
  output logic              start_of_packet,
  output logic              end_of_packet,
  output logic              payload_valid,
  input  logic              engine_ready,
  output logic              drop_err,
  output logic              timeout_err
);

  localparam int unsigned       NB        = DATA_W / 8;
  localparam int unsigned       BC_W      = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0]  LAST_FULL = CNT_W'(NB - 1);
  localparam logic [BC_W-1:0]   MAX_CNT   = BC_W'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, SOP, STREAM, EOP, GUARD, WAIT_RDY} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [6:0]          flow_q, flow_d;
  logic [CNT_W-1:0]    nbytes_q, nbytes_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                eof_q, eof_d;
  logic                have_q, have_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic                drop_q, drop_d;
  logic                rd;
  logic [CNT_W-1:0]    last_idx;
  logic [DATA_W-1:0]   word_sh;

`ifdef PCRE_FEED_TIMEOUT_EN
  localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            tout_q, tout_d;
`endif

  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    flow_d          = flow_q;
    nbytes_d        = nbytes_q;
    idx_d           = idx_q;
    eof_d           = eof_q;
    have_d          = have_q;
    bcnt_d          = bcnt_q;
    drop_d          = 1'b0;
    rd              = 1'b0;
    start_of_packet = 1'b0;
    end_of_packet   = 1'b0;
    payload_valid   = 1'b0;
    fifo_out        = '0;
    last_idx        = eof_q ? (nbytes_q - 1'b1) : LAST_FULL;
    word_sh         = word_q << {idx_q, 3'b000};
`ifdef PCRE_FEED_TIMEOUT_EN
    tmo_d           = tmo_q;
    tout_d          = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!in_empty && engine_ready) begin
          rd = 1'b1;
          if (in_sof) begin
            word_d   = in_data;
            flow_d   = in_flow;
            nbytes_d = in_bytes;
            eof_d    = in_eof;
            idx_d    = '0;
            have_d   = 1'b1;
            bcnt_d   = '0;
            state_d  = SOP;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      SOP: begin
        start_of_packet = 1'b1;
        state_d = (eof_q && nbytes_q == '0) ? EOP : STREAM;
      end
      STREAM: begin
        // have_q low means the previous word is spent and the FIFO ran dry.
        if (!have_q) begin
          if (!in_empty) begin
            rd       = 1'b1;
            word_d   = in_data;
            nbytes_d = in_bytes;
            eof_d    = in_eof;
            idx_d    = '0;
            have_d   = 1'b1;
          end
        end else if (eof_q && nbytes_q == '0) begin
          state_d = EOP;
        end else begin
          if (bcnt_q < MAX_CNT) begin
            payload_valid = 1'b1;
            fifo_out      = word_sh[DATA_W-1 -: 8];
            bcnt_d        = bcnt_q + 1'b1;
          end
          if (idx_q != last_idx) begin
            idx_d = idx_q + 1'b1;
          end else if (eof_q) begin
            state_d = EOP;
          end else if (!in_empty) begin
            rd       = 1'b1;
            word_d   = in_data;
            nbytes_d = in_bytes;
            eof_d    = in_eof;
            idx_d    = '0;
          end else begin
            have_d = 1'b0;
          end
        end
      end
      EOP: begin
        end_of_packet = 1'b1;
        state_d = GUARD;
      end
      GUARD: begin
        state_d = WAIT_RDY;
`ifdef PCRE_FEED_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      WAIT_RDY: begin
        if (engine_ready) begin
          state_d = IDLE;
`ifdef PCRE_FEED_TIMEOUT_EN
        end else if (tmo_q == TO_LAST) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      flow_q   <= '0;
      nbytes_q <= '0;
      idx_q    <= '0;
      eof_q    <= 1'b0;
      have_q   <= 1'b0;
      bcnt_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      flow_q   <= flow_d;
      nbytes_q <= nbytes_d;
      idx_q    <= idx_d;
      eof_q    <= eof_d;
      have_q   <= have_d;
      bcnt_q   <= bcnt_d;
      drop_q   <= drop_d;
    end
  end

`ifdef PCRE_FEED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      tout_q <= tout_d;
    end
  end
  assign timeout_err = tout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Pop request depends on live FIFO/engine inputs, so mask it while reset is held.
  assign in_rd_en = rd & rst;
  assign flow_out = flow_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_pcre_payload_feeder.sv
// Scoreboard bench for pcre_payload_feeder: FIFO/engine models drive the DUT, a monitor checks the byte stream.
module tb_pcre_payload_feeder;
  localparam int DATA_W      = 64;
  localparam int CNT_W       = 4;
  localparam int MAX_BYTES   = 20;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  in_bytes;
  logic              in_sof, in_eof, in_empty, in_rd_en;
  logic [6:0]        in_flow, flow_out;
  logic [7:0]        fifo_out;
  logic              start_of_packet, end_of_packet, payload_valid;
  logic              engine_ready, drop_err, timeout_err;

  always #5 clk = ~clk;

  pcre_payload_feeder #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_BYTES(MAX_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_bytes(in_bytes), .in_sof(in_sof),
    .in_eof(in_eof), .in_flow(in_flow), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .fifo_out(fifo_out), .flow_out(flow_out), .start_of_packet(start_of_packet),
    .end_of_packet(end_of_packet), .payload_valid(payload_valid),
    .engine_ready(engine_ready), .drop_err(drop_err), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  nbytes;
    logic        sof;
    logic        eof;
    logic [6:0]  flow;
  } word_t;

  // kind: 0 = start, 1 = byte, 2 = end; delta 0 = timing unchecked; popf -1 = rd_en unchecked
  typedef struct {
    int         kind;
    logic [7:0] val;
    logic [6:0] flow;
    int         delta;
    int         popf;
  } evt_t;

  word_t fifo[$];
  evt_t  exp_q[$];
  int    sofpop_q[$];
  int    sop_log[$], eop_log[$], tout_log[$];
  int    drop_exp = 0, drops_seen = 0;
  int    n_chk = 0, n_fail = 0;
  int    cyc = 0;
  int    last_evt = 0;
  int    hold_len = 0;
  int    rdy_cnt = 0;
  bit    rand_hold = 0;
  bit    gap_en = 0;
  bit    in_pkt = 0;
  bit    eop_pending = 0;
  bit    pop_now = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void fail_msg(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO side: decide pops at negedge, retire and present the new head just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      pop_now = 1'b0;
      if (rst && in_rd_en) begin
        pop_now = 1'b1;
        check("rd_en_while_empty", in_empty, 1'b0);
        if (!in_pkt) check("idle_pop_needs_ready", engine_ready, 1'b1);
        if (!in_empty && fifo.size() > 0 && fifo[0].sof) sofpop_q.push_back(cyc);
      end
    end
  end

  initial begin
    word_t junk;
    in_empty = 1'b1; in_data = '0; in_bytes = '0; in_sof = 1'b0; in_eof = 1'b0; in_flow = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_now && fifo.size() > 0) junk = fifo.pop_front();
      if (fifo.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        in_empty = 1'b0;
        in_data  = fifo[0].data;
        in_bytes = fifo[0].nbytes;
        in_sof   = fifo[0].sof;
        in_eof   = fifo[0].eof;
        in_flow  = fifo[0].flow;
      end else begin
        in_empty = 1'b1;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
      end
    end
  end

  // Engine side: drops ready the cycle after each end_of_packet for a chosen number of cycles.
  initial begin
    engine_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_cnt > 0) rdy_cnt--;
      if (eop_pending) begin
        eop_pending = 0;
        rdy_cnt = rand_hold ? int'($urandom_range(0, 25)) : hold_len;
      end
      engine_ready = (rdy_cnt == 0);
    end
  end

  initial begin
    evt_t e;
    int   p;
    forever begin
      @(negedge clk);
      if (!rst) continue;
      check("framing_exclusive",
            (32'(start_of_packet) + 32'(payload_valid) + 32'(end_of_packet)) > 1, 1'b0);
`ifndef PCRE_FEED_TIMEOUT_EN
      check("timeout_err_tied_low", timeout_err, 1'b0);
`endif
      if (start_of_packet) begin
        sop_log.push_back(cyc);
        if (exp_q.size() == 0) fail_msg("unexpected_sop");
        else begin
          e = exp_q.pop_front();
          check("sop_kind", e.kind, 0);
          check("sop_flow", flow_out, e.flow);
        end
        if (sofpop_q.size() > 0) begin
          p = sofpop_q.pop_front();
          check("sop_latency", cyc, p + 1);
        end else fail_msg("sop_without_sof_pop");
        in_pkt = 1;
        last_evt = cyc;
      end
      if (payload_valid) begin
        if (exp_q.size() == 0) fail_msg("unexpected_byte");
        else begin
          e = exp_q.pop_front();
          check("byte_kind", e.kind, 1);
          check("byte_value", fifo_out, e.val);
          check("byte_flow", flow_out, e.flow);
          if (e.delta > 0) check("byte_gap", cyc - last_evt, e.delta);
          if (e.popf >= 0) check("byte_rd_en", in_rd_en, e.popf);
        end
        last_evt = cyc;
      end
      if (end_of_packet) begin
        eop_log.push_back(cyc);
        eop_pending = 1;
        if (exp_q.size() == 0) fail_msg("unexpected_eop");
        else begin
          e = exp_q.pop_front();
          check("eop_kind", e.kind, 2);
          check("eop_flow", flow_out, e.flow);
          if (e.delta > 0) check("eop_gap", cyc - last_evt, e.delta);
        end
        in_pkt = 0;
        last_evt = cyc;
      end
      if (drop_err) begin
        drops_seen++;
        check("drop_expected", drop_exp > 0, 1'b1);
        if (drop_exp > 0) drop_exp--;
      end
      if (timeout_err) tout_log.push_back(cyc);
    end
  end

  // Reference: a packet of n bytes yields start, the first min(n, MAX_BYTES) bytes in order, then end.
  task automatic push_pkt(input int n, input logic [6:0] f, input bit tight, input logic [23:0] pre);
    logic [7:0] b[$];
    word_t      w;
    evt_t       e;
    int         nw, idx, ne;
    for (int i = 0; i < n; i++) b.push_back(i < 3 ? pre[23 - 8*i -: 8] : 8'($urandom));
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int k = 0; k < nw; k++) begin
      w.data   = {$urandom, $urandom};
      for (int j = 0; j < 8; j++) begin
        idx = k * 8 + j;
        if (idx < n) w.data[63 - 8*j -: 8] = b[idx];
      end
      w.sof    = (k == 0);
      w.eof    = (k == nw - 1);
      w.nbytes = w.eof ? 4'(n - 8 * k) : 4'd8;
      w.flow   = (k == 0) ? f : 7'($urandom);
      fifo.push_back(w);
    end
    e.kind = 0; e.val = '0; e.flow = f; e.delta = 0; e.popf = -1;
    exp_q.push_back(e);
    ne = (n < MAX_BYTES) ? n : MAX_BYTES;
    for (int i = 0; i < ne; i++) begin
      e.kind  = 1;
      e.val   = b[i];
      e.delta = tight ? 1 : 0;
      e.popf  = tight ? int'((i % 8 == 7) && (i / 8 < nw - 1)) : -1;
      exp_q.push_back(e);
    end
    e.kind  = 2;
    e.val   = '0;
    e.popf  = -1;
    e.delta = tight ? 1 + ((n > MAX_BYTES) ? n - MAX_BYTES : 0) : 0;
    exp_q.push_back(e);
  endtask

  task automatic push_orphan();
    word_t w;
    w.data = {$urandom, $urandom};
    w.nbytes = 4'd8;
    w.sof = 1'b0;
    w.eof = 1'($urandom);
    w.flow = 7'($urandom);
    fifo.push_back(w);
    drop_exp++;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while ((exp_q.size() > 0 || fifo.size() > 0 || drop_exp > 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, k < budget, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, d0, k;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_outputs",
             {in_rd_en, fifo_out, flow_out, start_of_packet, end_of_packet, payload_valid, drop_err, timeout_err}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    push_pkt(3, 7'd5, 1, 24'hAABBCC);
    wait_drain(60, "drain_3byte");
    push_pkt(12, 7'h21, 1, 24'($urandom));
    wait_drain(60, "drain_12byte");
    push_pkt(0, 7'h33, 1, 24'($urandom));
    wait_drain(60, "drain_zero_len");
    push_pkt(8, 7'h11, 1, 24'($urandom));
    push_pkt(MAX_BYTES, 7'h12, 1, 24'($urandom));
    push_pkt(27, 7'h13, 1, 24'($urandom));
    wait_drain(200, "drain_saturation");

    hold_len = 20;
    n0 = sop_log.size();
    push_pkt(5, 7'h41, 1, 24'($urandom));
    push_pkt(5, 7'h42, 1, 24'($urandom));
    wait_drain(200, "drain_ready_gate");
    if (sop_log.size() > n0 + 1 && eop_log.size() > n0)
      check("ready_gate_sop_gap", sop_log[n0 + 1] - eop_log[n0], 23);
    else fail_msg("ready_gate_missing_sop");
    hold_len = 0;
    repeat (25) @(negedge clk);

    d0 = drops_seen;
    n0 = sop_log.size();
    push_orphan();
    wait_drain(60, "drain_orphan");
    check("orphan_drop_once", drops_seen - d0, 1);
    check("orphan_no_framing", sop_log.size(), n0);

    push_pkt(30, 7'h55, 1, 24'($urandom));
    k = 0;
    while (!payload_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reset_wait_stream", k < 100, 1'b1);
    repeat (4) @(negedge clk);
    n0 = eop_log.size();
    #2 rst = 1'b0;
    #1 check("midstream_reset_outputs",
             {in_rd_en, fifo_out, flow_out, start_of_packet, end_of_packet, payload_valid, drop_err, timeout_err}, '0);
    fifo.delete(); exp_q.delete(); sofpop_q.delete();
    in_pkt = 0; drop_exp = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("no_eop_after_reset", eop_log.size(), n0);
    push_pkt(3, 7'h66, 1, 24'h123456);
    wait_drain(60, "drain_after_reset");

`ifdef PCRE_FEED_TIMEOUT_EN
    hold_len = 100;
    n0 = eop_log.size();
    d0 = tout_log.size();
    push_pkt(1, 7'h77, 1, 24'($urandom));
    wait_drain(60, "drain_timeout_pkt");
    k = 0;
    while (tout_log.size() <= d0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (tout_log.size() > d0 && eop_log.size() > n0)
      check("timeout_delay", tout_log[d0] - eop_log[n0], 18);
    else fail_msg("timeout_missing");
    hold_len = 0;
    repeat (110) @(negedge clk);
`endif

    gap_en = 1;
    rand_hold = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) push_orphan();
      else push_pkt(int'($urandom_range(0, 40)), 7'($urandom), 0, 24'($urandom));
    end
    wait_drain(20000, "drain_random");
    check("final_queues_empty", exp_q.size() + fifo.size() + drop_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
